// File: rtl/mux7_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux7_rr_arbiter
//
// Round-robin arbiter that owns the select of a shared 7:1 one-bit mux.
// One of seven requesters is granted at a time. The mux select follows the
// grant. When no grant is active, the select parks on the unused code 7,
// which gives a 0 output.
//
// A single grant lasts at most MAX_HOLD consecutive cycles. After that it is
// offered to the other requesters in rotating order, so no requester starves.
//
// Parameters
//   MAX_HOLD : maximum consecutive cycles of one grant (1..256)
//
// Ports
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   Req   : request vector, Req[i] asks for mux input i
//   Gnt   : one-hot grant (registered), zero when idle
//   Sel   : mux select (registered), index of the granted input or 3'b111
//   Busy  : registered, high while any grant is active
// -----------------------------------------------------------------------------
module mux7_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] Req,
    output logic [6:0] Gnt,
    output logic [2:0] Sel,
    output logic       Busy
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [2:0]    SEL_IDLE  = 3'b111;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t        r_state;
    logic [HW-1:0] r_hold_cnt;
    logic [2:0]    r_ptr;

    // Current owner status. Gnt is zero in IDLE, so the reduction below is
    // safe in both states and avoids indexing Req with the parked select.
    logic       w_owner_req;
    logic       w_hold_done;
    logic       w_release;
    logic [2:0] w_next_ptr;

    assign w_owner_req = |(Req & Gnt);
    assign w_hold_done = (r_hold_cnt == HOLD_LAST);
    assign w_release   = (r_state == S_GRANT) && (!w_owner_req || w_hold_done);
    assign w_next_ptr  = (Sel == 3'd6) ? 3'd0 : Sel + 3'd1;

    // Search inputs. In IDLE the search starts at the stored pointer over all
    // requests. On release it starts just past the owner, and the owner is
    // masked out so another requester gets the grant first.
    logic [6:0] w_search_req;
    logic [2:0] w_search_base;

    assign w_search_req  = (r_state == S_GRANT) ? (Req & ~Gnt) : Req;
    assign w_search_base = (r_state == S_GRANT) ? w_next_ptr : r_ptr;

    // Rotate the request vector so that slot 0 corresponds to the base
    // index. Each slot also carries the original index it came from.
    logic [2:0] w_rot_idx [7];
    logic [6:0] w_rot_req;

    genvar gi;
    generate
        for (gi = 0; gi < 7; gi++) begin : g_rot
            logic [3:0] w_sum;
            assign w_sum          = {1'b0, w_search_base} + 4'(gi);
            assign w_rot_idx[gi]  = (w_sum >= 4'd7) ? 3'(w_sum - 4'd7) : w_sum[2:0];
            assign w_rot_req[gi]  = w_search_req[w_rot_idx[gi]];
        end
    endgenerate

    // Pick the first asserted slot in rotated order. The loop scans downward
    // so that the lowest slot, which is closest to the base, is assigned last
    // and therefore wins.
    logic       w_found;
    logic [2:0] w_win;
    logic [6:0] w_win_onehot;

    always_comb begin
        w_found = 1'b0;
        w_win   = SEL_IDLE;
        for (int i = 6; i >= 0; i--) begin
            if (w_rot_req[i]) begin
                w_found = 1'b1;
                w_win   = w_rot_idx[i];
            end
        end
    end

    assign w_win_onehot = 7'(1) << w_win;

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            r_ptr      <= 3'd0;
            Gnt        <= 7'd0;
            Sel        <= SEL_IDLE;
            Busy       <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                if (w_found) begin
                    r_state    <= S_GRANT;
                    r_hold_cnt <= '0;
                    Gnt        <= w_win_onehot;
                    Sel        <= w_win;
                    Busy       <= 1'b1;
                end
            end else begin
                if (!w_release) begin
                    r_hold_cnt <= r_hold_cnt + 1'b1;
                end else begin
                    r_ptr <= w_next_ptr;
                    if (w_found) begin
                        // Handoff on the same edge: the grants never overlap
                        // and there is no idle cycle between them.
                        r_hold_cnt <= '0;
                        Gnt        <= w_win_onehot;
                        Sel        <= w_win;
                    end else if (w_owner_req) begin
                        // Timeout with no competitor: the owner keeps the
                        // grant and its hold window restarts.
                        r_hold_cnt <= '0;
                    end else begin
                        r_state    <= S_IDLE;
                        r_hold_cnt <= '0;
                        Gnt        <= 7'd0;
                        Sel        <= SEL_IDLE;
                        Busy       <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
